load_store_sequencer: RTL and testbench
=======================================

// Module: load_store_sequencer
// PURPOSE
//  Sequences one load/store at a time from execute into the memory access unit, and the result into writeback.
//  Captures request, pulses memory `available` for one cycle, samples the registered data/faults the next cycle.
//  Folds the three memory faults into one RISC-V trap cause; outputs held under a valid/ready handshake.
// PARAMETERS
//  XLEN          32  data/address width; only 32 supported
//  REG_W         5   destination register index width
//  CAUSE_ILLEGAL 2   cause code, invalid op size (op=2'b11)
//  CAUSE_LD_MIS  4 / CAUSE_LD_ACC 5   load misaligned / load access fault
//  CAUSE_ST_MIS  6 / CAUSE_ST_ACC 7   store misaligned / store access fault
// PORTS
//  clk          in  1     clock
//  reset        in  1     synchronous reset, active-high
//  flush        in  1     discard in-flight/pending result (pipeline redirect)
//  req_valid    in  1     execute presents a memory request
//  req_ready    out 1     request accepted when req_valid&req_ready at posedge
//  req_is_write in  1     1=store, 0=load
//  req_unsigned in  1     zero-extend load (LBU/LHU)
//  req_op       in  2     00 byte, 01 half, 10 word, 11 invalid
//  req_addr     in  XLEN  effective address
//  req_wdata    in  XLEN  store data
//  req_rd       in  REG_W load destination register
//  mem_available out 1    to memory unit `available`
//  mem_is_write/mem_is_unsigned out 1, mem_op out 2, mem_addr/mem_in out XLEN: to memory unit
//  mem_out      in  XLEN  memory unit read data
//  mem_op_fault / mem_addr_fault / mem_access_fault  in 1  memory unit faults
//  wb_valid     out 1     result available to writeback
//  wb_ready     in  1     writeback consumes result
//  wb_data      out XLEN  load data (0 for stores and traps)
//  wb_rd        out REG_W destination register
//  wb_rd_we     out 1     1 only for non-trapping load with rd!=0
//  wb_trap      out 1     request faulted
//  wb_cause     out 4     trap cause (0 when !wb_trap)
//  wb_tval      out XLEN  faulting address (0 when !wb_trap)
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; req_ready=0 in reset cycle, 1 after. Reset mid-op abandons it, no wb.
//  States: IDLE, ISSUE, WAIT, DONE. req_ready = (IDLE) | (DONE & wb_ready & !flush).
//  Accept: latch is_write/unsigned/op/addr/wdata/rd into request regs -> ISSUE.
//  ISSUE: mem_available=1 exactly one cycle; -> WAIT. mem_* driven from request regs, stable ISSUE..WAIT.
//  WAIT: mem_available=0; sample mem_out + faults; load wb regs; -> DONE (or IDLE if flush seen).
//  DONE: wb_valid=1, wb_* held stable until wb_ready. wb_ready & new accept -> ISSUE; else -> IDLE.
//  Latency: accept at edge N -> wb_valid high from cycle N+3. Back-to-back throughput: 1 per 3 cycles.
//  Trap priority: op_fault > addr_fault > access_fault; causes per parameters, chosen by latched is_write.
//  Trap: wb_trap=1, wb_tval=addr, wb_data=0, wb_rd_we=0. Store: wb_data=0, wb_rd_we=0.
//  flush in IDLE: no effect. In ISSUE/WAIT: memory access still completes (store side effect kept);
//   result discarded, WAIT -> IDLE, wb_valid never rises. In DONE: wb_valid drops next cycle -> IDLE.
//  flush takes priority over a simultaneous wb_ready/req_valid; no request accepted that cycle.
//  mem_available is never high two consecutive cycles.
// TESTING
//  LW addr 0x100, mem_out 0xDEADBEEF, rd=5 -> wb_valid at N+3, wb_data 0xDEADBEEF, rd_we=1, trap=0.
//  SH addr 0x103 with mem_addr_fault=1 -> wb_trap=1, cause 6, tval 0x103, rd_we=0.
//  op=2'b11 load with addr_fault also 1 -> cause 2 (op fault wins), tval=addr.
//  wb_ready low 5 cycles in DONE -> wb_* unchanged; then wb_ready+req_valid -> next ISSUE, no bubble.
//  flush during WAIT of SW -> mem_available pulsed once, wb_valid stays 0, back in IDLE next cycle.
//  reset asserted in ISSUE -> all outputs 0 next cycle, req_ready=1 the cycle after reset drops.

Source files
------------

// File: rtl/load_store_sequencer.sv
// load_store_sequencer
//   Passes one load/store at a time from execute to the memory access unit,
//   then hands the result, or a trap, to writeback.
//   Flow: accept request -> ISSUE (pulse mem_available) -> WAIT (sample the
//   memory unit's registered data and faults) -> DONE (hold the result until
//   wb_ready). A new request can be accepted in the same cycle that DONE
//   retires, so back-to-back requests complete one every three cycles.
// Ports
//   clk, reset            clock; synchronous active-high reset
//   flush                 drop any in-flight or pending result
//   req_*                 request from execute (valid/ready handshake)
//   mem_*  (out)          command to the memory unit, held stable ISSUE..WAIT
//   mem_out, mem_*_fault  response from the memory unit, sampled in WAIT
//   wb_*                  result to writeback (valid/ready handshake)
module load_store_sequencer #(
   parameter int unsigned XLEN          = 32,
   parameter int unsigned REG_W         = 5,
   parameter int unsigned CAUSE_ILLEGAL = 2,
   parameter int unsigned CAUSE_LD_MIS  = 4,
   parameter int unsigned CAUSE_LD_ACC  = 5,
   parameter int unsigned CAUSE_ST_MIS  = 6,
   parameter int unsigned CAUSE_ST_ACC  = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_is_write,
   input  logic             req_unsigned,
   input  logic [1:0]       req_op,
   input  logic [XLEN-1:0]  req_addr,
   input  logic [XLEN-1:0]  req_wdata,
   input  logic [REG_W-1:0] req_rd,
   output logic             mem_available,
   output logic             mem_is_write,
   output logic             mem_is_unsigned,
   output logic [1:0]       mem_op,
   output logic [XLEN-1:0]  mem_addr,
   output logic [XLEN-1:0]  mem_in,
   input  logic [XLEN-1:0]  mem_out,
   input  logic             mem_op_fault,
   input  logic             mem_addr_fault,
   input  logic             mem_access_fault,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [XLEN-1:0]  wb_data,
   output logic [REG_W-1:0] wb_rd,
   output logic             wb_rd_we,
   output logic             wb_trap,
   output logic [3:0]       wb_cause,
   output logic [XLEN-1:0]  wb_tval
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   state_t             state_q, state_d;

   // Request registers: drive the memory unit for the whole ISSUE..WAIT window.
   logic               is_write_q, is_write_d;
   logic               is_unsigned_q, is_unsigned_d;
   logic [1:0]         op_q, op_d;
   logic [XLEN-1:0]    addr_q, addr_d;
   logic [XLEN-1:0]    wdata_q, wdata_d;
   logic [REG_W-1:0]   rd_q, rd_d;

   // A flush seen during ISSUE must still discard the result in WAIT.
   logic               flush_pend_q, flush_pend_d;

   // Writeback registers, loaded once in WAIT and held through DONE.
   logic [XLEN-1:0]    wb_data_q, wb_data_d;
   logic [REG_W-1:0]   wb_rd_q, wb_rd_d;
   logic               wb_rd_we_q, wb_rd_we_d;
   logic               wb_trap_q, wb_trap_d;
   logic [3:0]         wb_cause_q, wb_cause_d;
   logic [XLEN-1:0]    wb_tval_q, wb_tval_d;

   logic               accept;
   logic               op_bad;
   logic [3:0]         cause;

   always_comb begin
      req_ready = !reset && ((state_q == IDLE) ||
                             ((state_q == DONE) && wb_ready && !flush));
   end

   assign accept = req_valid && req_ready;

   // Size 2'b11 is illegal regardless of what the memory unit reports.
   assign op_bad = mem_op_fault || (op_q == 2'b11);

   always_comb begin
      cause = '0;
      if (op_bad) begin
         cause = 4'(CAUSE_ILLEGAL);
      end else if (mem_addr_fault) begin
         cause = is_write_q ? 4'(CAUSE_ST_MIS) : 4'(CAUSE_LD_MIS);
      end else if (mem_access_fault) begin
         cause = is_write_q ? 4'(CAUSE_ST_ACC) : 4'(CAUSE_LD_ACC);
      end
   end

   always_comb begin
      state_d       = state_q;
      is_write_d    = is_write_q;
      is_unsigned_d = is_unsigned_q;
      op_d          = op_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rd_d          = rd_q;
      flush_pend_d  = flush_pend_q;
      wb_data_d     = wb_data_q;
      wb_rd_d       = wb_rd_q;
      wb_rd_we_d    = wb_rd_we_q;
      wb_trap_d     = wb_trap_q;
      wb_cause_d    = wb_cause_q;
      wb_tval_d     = wb_tval_q;

      if (accept) begin
         is_write_d    = req_is_write;
         is_unsigned_d = req_unsigned;
         op_d          = req_op;
         addr_d        = req_addr;
         wdata_d       = req_wdata;
         rd_d          = req_rd;
      end

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            flush_pend_d = flush;
            state_d      = WAIT;
         end
         WAIT: begin
            flush_pend_d = 1'b0;
            if (flush || flush_pend_q) begin
               state_d = IDLE;
            end else begin
               state_d    = DONE;
               wb_trap_d  = (cause != 4'd0);
               wb_cause_d = cause;
               wb_tval_d  = (cause != 4'd0) ? addr_q : '0;
               wb_data_d  = ((cause != 4'd0) || is_write_q) ? '0 : mem_out;
               wb_rd_d    = rd_q;
               wb_rd_we_d = (cause == 4'd0) && !is_write_q && (rd_q != '0);
            end
         end
         DONE: begin
            if (flush) begin
               state_d = IDLE;
            end else if (wb_ready) begin
               state_d = accept ? ISSUE : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         is_write_q    <= 1'b0;
         is_unsigned_q <= 1'b0;
         op_q          <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         rd_q          <= '0;
         flush_pend_q  <= 1'b0;
         wb_data_q     <= '0;
         wb_rd_q       <= '0;
         wb_rd_we_q    <= 1'b0;
         wb_trap_q     <= 1'b0;
         wb_cause_q    <= '0;
         wb_tval_q     <= '0;
      end else begin
         state_q       <= state_d;
         is_write_q    <= is_write_d;
         is_unsigned_q <= is_unsigned_d;
         op_q          <= op_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         rd_q          <= rd_d;
         flush_pend_q  <= flush_pend_d;
         wb_data_q     <= wb_data_d;
         wb_rd_q       <= wb_rd_d;
         wb_rd_we_q    <= wb_rd_we_d;
         wb_trap_q     <= wb_trap_d;
         wb_cause_q    <= wb_cause_d;
         wb_tval_q     <= wb_tval_d;
      end
   end

   always_comb begin
      mem_available   = (state_q == ISSUE);
      mem_is_write    = is_write_q;
      mem_is_unsigned = is_unsigned_q;
      mem_op          = op_q;
      mem_addr        = addr_q;
      mem_in          = wdata_q;
      wb_valid        = (state_q == DONE);
      wb_data         = wb_data_q;
      wb_rd           = wb_rd_q;
      wb_rd_we        = wb_rd_we_q;
      wb_trap         = wb_trap_q;
      wb_cause        = wb_cause_q;
      wb_tval         = wb_tval_q;
   end

endmodule

// File: tb/tb_load_store_sequencer.sv
module tb_load_store_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_is_write = 1'b0;
   logic        req_unsigned = 1'b0;
   logic [1:0]  req_op = '0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [4:0]  req_rd = '0;
   logic        mem_available;
   logic        mem_is_write;
   logic        mem_is_unsigned;
   logic [1:0]  mem_op;
   logic [31:0] mem_addr;
   logic [31:0] mem_in;
   logic [31:0] mem_out = '0;
   logic        mem_op_fault = 1'b0;
   logic        mem_addr_fault = 1'b0;
   logic        mem_access_fault = 1'b0;
   logic        wb_valid;
   logic        wb_ready = 1'b0;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_rd_we;
   logic        wb_trap;
   logic [3:0]  wb_cause;
   logic [31:0] wb_tval;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   load_store_sequencer #(.XLEN(32), .REG_W(5)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_is_write(req_is_write), .req_unsigned(req_unsigned),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_rd(req_rd),
      .mem_available(mem_available), .mem_is_write(mem_is_write),
      .mem_is_unsigned(mem_is_unsigned), .mem_op(mem_op),
      .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out),
      .mem_op_fault(mem_op_fault), .mem_addr_fault(mem_addr_fault),
      .mem_access_fault(mem_access_fault),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
      .wb_rd(wb_rd), .wb_rd_we(wb_rd_we), .wb_trap(wb_trap),
      .wb_cause(wb_cause), .wb_tval(wb_tval)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Move to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected writeback result from the trap rules.
   function automatic void model(input logic w, input logic [1:0] op,
                                 input logic [31:0] addr, input logic [31:0] mout,
                                 input logic [4:0] rd, input logic fop,
                                 input logic faddr, input logic facc,
                                 output logic [31:0] e_data, output logic e_we,
                                 output logic e_trap, output logic [3:0] e_cause,
                                 output logic [31:0] e_tval);
      int c;
      c = 0;
      if (fop || op == 2'b11) c = 2;
      else if (faddr)         c = w ? 6 : 4;
      else if (facc)          c = w ? 7 : 5;
      e_trap  = (c != 0);
      e_cause = 4'(c);
      e_tval  = e_trap ? addr : 32'h0;
      e_data  = (e_trap || w) ? 32'h0 : mout;
      e_we    = !e_trap && !w && (rd != 0);
   endfunction

   // Runs one request from IDLE, or from DONE (wb_ready raised here), and
   // leaves the DUT holding the result in DONE with wb_ready low.
   task automatic run_txn(input logic w, input logic u, input logic [1:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic [31:0] mout,
                          input logic fop, input logic faddr, input logic facc,
                          input int unsigned stall);
      logic [31:0] e_data, e_tval;
      logic        e_we, e_trap;
      logic [3:0]  e_cause;
      model(w, op, addr, mout, rd, fop, faddr, facc,
            e_data, e_we, e_trap, e_cause, e_tval);
      req_valid = 1'b1; req_is_write = w; req_unsigned = u; req_op = op;
      req_addr = addr; req_wdata = wdata; req_rd = rd; wb_ready = 1'b1;
      #1;
      check("req_ready_accept", req_ready, 1);
      step();
      // ISSUE: request inputs scrambled to show the command is latched;
      // memory response is junk here because WAIT is the sampling cycle.
      req_valid = 1'b0; wb_ready = 1'b0;
      req_addr = $urandom; req_wdata = $urandom; req_op = 2'($urandom);
      req_rd = 5'($urandom); req_is_write = ~w;
      mem_out = $urandom; mem_op_fault = 1'($urandom);
      mem_addr_fault = 1'($urandom); mem_access_fault = 1'($urandom);
      #1;
      check("issue_avail", mem_available, 1);
      check("issue_addr", mem_addr, addr);
      check("issue_wdata", mem_in, wdata);
      check("issue_op", mem_op, op);
      check("issue_wr", mem_is_write, w);
      check("issue_uns", mem_is_unsigned, u);
      check("issue_wb_valid", wb_valid, 0);
      check("issue_req_ready", req_ready, 0);
      step();
      mem_out = mout; mem_op_fault = fop;
      mem_addr_fault = faddr; mem_access_fault = facc;
      #1;
      check("wait_avail", mem_available, 0);
      check("wait_addr", mem_addr, addr);
      check("wait_wb_valid", wb_valid, 0);
      step();
      mem_out = $urandom; mem_op_fault = 1'($urandom);
      mem_addr_fault = 1'($urandom); mem_access_fault = 1'($urandom);
      #1;
      check("done_valid", wb_valid, 1);
      check("done_avail", mem_available, 0);
      check("done_data", wb_data, e_data);
      check("done_rd", wb_rd, rd);
      check("done_rd_we", wb_rd_we, e_we);
      check("done_trap", wb_trap, e_trap);
      check("done_cause", wb_cause, e_cause);
      check("done_tval", wb_tval, e_tval);
      for (int i = 0; i < int'(stall); i++) begin
         step();
         mem_out = $urandom;
         #1;
         check("hold_valid", wb_valid, 1);
         check("hold_data", wb_data, e_data);
         check("hold_trap", wb_trap, e_trap);
         check("hold_cause", wb_cause, e_cause);
         check("hold_tval", wb_tval, e_tval);
         check("hold_rd_we", wb_rd_we, e_we);
      end
   endtask

   // Retire the held result with no new request; DUT returns to IDLE.
   task automatic drain();
      wb_ready = 1'b1; req_valid = 1'b0;
      step();
      wb_ready = 1'b0;
      #1;
      check("drain_wb_valid", wb_valid, 0);
      check("drain_req_ready", req_ready, 1);
      check("drain_avail", mem_available, 0);
   endtask

   // Store flushed in ISSUE (phase 0) or WAIT (phase 1).
   task automatic flush_txn(input int phase);
      req_valid = 1'b1; req_is_write = 1'b1; req_op = 2'b10;
      req_addr = 32'h200; req_wdata = 32'h1234_5678; req_rd = 5'd0;
      step();
      req_valid = 1'b0;
      flush = (phase == 0);
      #1;
      check("flush_issue_avail", mem_available, 1);
      step();
      flush = (phase == 1);
      #1;
      check("flush_wait_avail", mem_available, 0);
      check("flush_wait_valid", wb_valid, 0);
      step();
      flush = 1'b0;
      #1;
      check("flush_idle_valid", wb_valid, 0);
      check("flush_idle_ready", req_ready, 1);
      check("flush_idle_avail", mem_available, 0);
      step();
      #1;
      check("flush_after_valid", wb_valid, 0);
   endtask

   initial begin
      // Reset
      step();
      step();
      check("rst_req_ready", req_ready, 0);
      check("rst_avail", mem_available, 0);
      check("rst_wb_valid", wb_valid, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_wb_trap", wb_trap, 0);
      check("rst_wb_cause", wb_cause, 0);
      check("rst_mem_addr", mem_addr, 0);
      reset = 1'b0;
      #1;
      check("post_rst_req_ready", req_ready, 1);

      // LW 0x100 -> 0xDEADBEEF, rd=5
      run_txn(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 5'd5, 32'hDEAD_BEEF,
              1'b0, 1'b0, 1'b0, 0);
      drain();
      // SH 0x103 misaligned -> cause 6
      run_txn(1'b1, 1'b0, 2'b01, 32'h103, 32'hAAAA_5555, 5'd3, 32'h1111_2222,
              1'b0, 1'b1, 1'b0, 0);
      drain();
      // Invalid size with addr fault also set -> cause 2
      run_txn(1'b0, 1'b0, 2'b11, 32'h0000_0F01, 32'h0, 5'd7, 32'h3333_4444,
              1'b1, 1'b1, 1'b0, 0);
      drain();
      // Load access fault -> cause 5; load to x0 -> no write enable
      run_txn(1'b0, 1'b1, 2'b00, 32'h8000_0000, 32'h0, 5'd9, 32'h55,
              1'b0, 1'b0, 1'b1, 0);
      drain();
      run_txn(1'b0, 1'b1, 2'b00, 32'h44, 32'h0, 5'd0, 32'h0000_00FF,
              1'b0, 1'b0, 1'b0, 0);
      // Held 5 cycles, then back-to-back accept while retiring
      run_txn(1'b0, 1'b0, 2'b01, 32'h52, 32'h0, 5'd12, 32'hFFFF_8001,
              1'b0, 1'b0, 1'b0, 5);
      run_txn(1'b1, 1'b0, 2'b10, 32'h60, 32'hCAFE_F00D, 5'd1, 32'h0,
              1'b0, 1'b0, 1'b1, 0);
      drain();

      // Flush in ISSUE and in WAIT
      flush_txn(0);
      flush_txn(1);

      // Flush in DONE beats simultaneous wb_ready + req_valid
      run_txn(1'b0, 1'b0, 2'b10, 32'h70, 32'h0, 5'd4, 32'h7777_7777,
              1'b0, 1'b0, 1'b0, 1);
      flush = 1'b1; wb_ready = 1'b1; req_valid = 1'b1;
      #1;
      check("done_flush_ready", req_ready, 0);
      step();
      flush = 1'b0; wb_ready = 1'b0; req_valid = 1'b0;
      #1;
      check("done_flush_valid", wb_valid, 0);
      check("done_flush_avail", mem_available, 0);
      check("done_flush_ready_idle", req_ready, 1);

      // Reset during ISSUE
      req_valid = 1'b1; req_is_write = 1'b0; req_op = 2'b10;
      req_addr = 32'h90; req_rd = 5'd6;
      step();
      req_valid = 1'b0;
      #1;
      check("rst_mid_avail_pre", mem_available, 1);
      reset = 1'b1;
      step();
      check("rst_mid_avail", mem_available, 0);
      check("rst_mid_wb_valid", wb_valid, 0);
      check("rst_mid_req_ready", req_ready, 0);
      check("rst_mid_mem_addr", mem_addr, 0);
      check("rst_mid_wb_data", wb_data, 0);
      reset = 1'b0;
      step();
      check("rst_mid_ready_after", req_ready, 1);
      check("rst_mid_no_wb", wb_valid, 0);
      check("rst_mid_no_avail", mem_available, 0);

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         logic [1:0] op;
         op = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         run_txn(1'($urandom), 1'($urandom), op, $urandom, $urandom,
                 5'($urandom), $urandom,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) drain();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
